pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register for the RISCV32 core. It is the successor to the fixed-payload stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB):
- Carries any payload width.
- Adds a valid/ready handshake, synchronous flush, an optional skid entry that fully registers the upstream ready, and a saturating stall counter.
- Sits between any two pipeline stages; one instance per stage boundary.

## Interface
Parameters:
- DATA_W, 32: payload width in bits; set to $bits of the stage struct.
- SKID, 1: 1 = two-entry skid stage, in_ready driven from a flop; 0 = single-entry stage, in_ready combinational.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush; drops all held entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage accepts the payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds a payload for downstream.
- out_ready  in  1  downstream accepts the payload this cycle.
- out_data  out  DATA_W  payload to downstream.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- stall_clr  in  1  synchronous clear of stall_cnt.

## Operation
Transfer rules:
- Input transfer: in_valid & in_ready.
- Output transfer: out_valid & out_ready.
- Payloads are never dropped except by flush or rst, and are never duplicated.
- Order is strictly preserved.

Storage and states:
- Storage is a main entry (drives out_*) plus, when SKID=1, a skid entry.
- States: EMPTY, MAIN (main entry valid), BOTH (main and skid valid; SKID=1 only).

State transitions, evaluated when flush=0:
- EMPTY: on input transfer, load main, go to MAIN.
- MAIN, input transfer with output transfer: load main, stay in MAIN.
- MAIN, input transfer without output transfer: load skid, go to BOTH. This applies only when SKID=1; when SKID=0 this case cannot occur.
- MAIN, output transfer without input transfer: go to EMPTY.
- BOTH, output transfer: move skid to main, go to MAIN. No input is accepted in BOTH.

in_ready:
- SKID=1: in_ready = (state != BOTH), taken from a flop; there is no combinational path from out_ready.
- SKID=0: in_ready = ~out_valid | out_ready.

Flush:
- flush=1 forces the next state to EMPTY and overrides all other transitions.
- A payload presented during a flush cycle is discarded. in_ready is not gated by flush.

Stall counter:
- Increments when out_valid & ~out_ready, holds at all-ones.
- stall_clr loads 0; it has priority over increment.
- flush does not affect the counter.

out_data:
- Undefined-but-stable while out_valid=0; it holds the last value and is not zeroed.

## Timing
Reset values:
- state=EMPTY.
- out_valid=0.
- out_data=0.
- in_ready: 1 when SKID=1; 1 when SKID=0, because out_valid=0.
- stall_cnt=0.

Latency and throughput:
- Latency is one cycle: data accepted at edge N appears on out_data after edge N.
- Throughput is 1 per cycle in steady state, for both SKID values.
- SKID=1: after the first stalled cycle with a new input, in_ready drops at the next edge. The second payload is caught in the skid entry.
- SKID=1: in_ready returns high the cycle after the BOTH→MAIN drain.

Reset and boundaries:
- rst asserted at any time clears all state immediately, independent of clk. Payloads in flight are lost.
- Counter saturation: all-ones plus a stall cycle stays all-ones; all-ones with stall_clr goes to 0.
- Simultaneous flush and stall_clr: both take effect.

## Structure
- riscv32_pkg additions:
  - typedef enum pipe_state_e {PS_EMPTY, PS_MAIN, PS_BOTH}.
  - localparam PIPE_CNT_W_DEFAULT = 16.
- Sub-module pipe_sat_cnt, parametrised by width, with inc/clr inputs. It will be reused for other performance counters.
- The stage structs (id_ex_t etc.) are passed through in_data and out_data by casting; no struct-specific logic lives here.

## Test plan
- Streaming, SKID=1: in_valid=1 and out_ready=1 for 8 cycles with data 0x1..0x8 → out_data 0x1..0x8 on consecutive cycles, one cycle behind; stall_cnt=0.
- Backpressure, SKID=1: stream 0xA, 0xB, 0xC with out_ready=0 from cycle 2 → 0xA held, 0xB in skid, in_ready=0 the next cycle, 0xC held upstream. Release out_ready → order 0xA, 0xB, 0xC; stall_cnt equals the number of stalled cycles.
- SKID=0 backpressure: out_valid=1 and out_ready=0 → in_ready=0 in the same cycle. out_ready=1 → in_ready=1 in the same cycle.
- Flush in BOTH state with in_valid=1, data 0xD → next cycle out_valid=0, 0xD not delivered; the next payload 0xE is delivered normally.
- Counter: CNT_W=4, stall for 20 cycles → stall_cnt=0xF. stall_clr → 0x0 the next cycle.
- rst pulse asserted mid-cycle while in MAIN → out_valid=0 and out_data=0 before the next clk edge; in_ready=1.

Source files
------------

// File: rtl/riscv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv32_pkg
// Description : Shared types and constants for the RISCV32 core pipeline.
// Revision    : 1.0 - pipeline stage register state type and counter width
// ============================================================================
package riscv32_pkg;

    // Occupancy of a flow-controlled pipeline stage register
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_MAIN  = 2'd1,
        PS_BOTH  = 2'd2
    } pipe_state_e;

    localparam int PIPE_CNT_W_DEFAULT = 16;

endpackage : riscv32_pkg
`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_cnt
// Description : Saturating up-counter with synchronous clear. Clear has
//               priority over increment; the count sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise increment unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : pipe_sat_cnt
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Flow-controlled pipeline stage register with valid/ready
//               handshake, synchronous flush, optional skid entry (registered
//               in_ready) and a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import riscv32_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = PIPE_CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;

    logic in_xfer;
    logic out_xfer;

    assign out_valid = (state_q != PS_EMPTY);
    assign out_data  = main_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Next occupancy and data movement; flush overrides everything and
    // leaves the data entries untouched so out_data stays stable
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = PS_EMPTY;
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = PS_MAIN;
                    end
                end
                PS_MAIN: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        // Only reachable with a skid entry: in_ready is
                        // low whenever the main entry is blocked otherwise
                        skid_d  = in_data;
                        state_d = PS_BOTH;
                    end else if (out_xfer) begin
                        state_d = PS_EMPTY;
                    end
                end
                PS_BOTH: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = PS_MAIN;
                    end
                end
                default: begin
                    state_d = PS_EMPTY;
                end
            endcase
        end
    end

    // Occupancy and payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PS_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;
            logic in_ready_d;

            // Upstream ready is a pure flop: low only while both entries hold data
            always_comb begin
                in_ready_d = (state_d != PS_BOTH);
            end

            // Registered upstream ready
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_no_skid
            // Single entry: accept when empty or when the held entry leaves now
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    pipe_sat_cnt #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid & ~out_ready),
        .clr (stall_clr),
        .cnt (stall_cnt)
    );

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg: a SKID=1
//               stage, a SKID=0 stage and a SKID=1 stage with a 4-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Stage A: SKID=1, 32-bit data, 16-bit counter
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall_clr;
    logic [31:0] a_in_data, a_out_data;
    logic [15:0] a_stall_cnt;

    // Stage B: SKID=0
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall_clr;
    logic [31:0] b_in_data, b_out_data;
    logic [15:0] b_stall_cnt;

    // Stage C: SKID=1, 4-bit counter
    logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_stall_clr;
    logic [31:0] c_in_data, c_out_data;
    logic [3:0]  c_stall_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .stall_cnt(a_stall_cnt), .stall_clr(a_stall_clr)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .stall_cnt(b_stall_cnt), .stall_clr(b_stall_clr)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .stall_cnt(c_stall_cnt), .stall_clr(c_stall_clr)
    );

    // Advance one clock edge; inputs change and outputs are sampled 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_a_out_valid got=%b exp=0", a_out_valid); end
        checks++;
        if (a_out_data !== 32'h0) begin failures++; $display("FAIL reset_a_out_data got=%h exp=0", a_out_data); end
        checks++;
        if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_a_in_ready got=%b exp=1", a_in_ready); end
        checks++;
        if (a_stall_cnt !== 16'h0) begin failures++; $display("FAIL reset_a_stall_cnt got=%h exp=0", a_stall_cnt); end
        checks++;
        if (b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_b_in_ready got=%b exp=1", b_in_ready); end
        checks++;
        if (c_out_valid !== 1'b0) begin failures++; $display("FAIL reset_c_out_valid got=%b exp=0", c_out_valid); end
    endtask

    task automatic test_streaming();
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_data = i;
            step();
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== 32'(i)) begin
                failures++;
                $display("FAIL stream_%0d got valid=%b data=%h exp valid=1 data=%h", i, a_out_valid, a_out_data, i);
            end
            checks++;
            if (a_in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready_%0d got=%b exp=1", i, a_in_ready); end
        end
        a_in_valid = 1'b0;
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", a_out_valid); end
        checks++;
        if (a_stall_cnt !== 16'h0) begin failures++; $display("FAIL stream_stall_cnt got=%h exp=0", a_stall_cnt); end
    endtask

    task automatic test_backpressure();
        a_in_valid  = 1'b1;
        a_in_data   = 32'hA;
        a_out_ready = 1'b1;
        step();                                  // A in main
        a_in_data   = 32'hB;
        a_out_ready = 1'b0;
        step();                                  // B in skid, stall 1
        checks++;
        if (a_out_data !== 32'hA || a_out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_hold_a got valid=%b data=%h exp valid=1 data=a", a_out_valid, a_out_data);
        end
        checks++;
        if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_low got=%b exp=0", a_in_ready); end
        a_in_data = 32'hC;
        step();                                  // stall 2, C held upstream
        checks++;
        if (a_in_ready !== 1'b0 || a_out_data !== 32'hA) begin
            failures++; $display("FAIL bp_still_full got in_ready=%b data=%h exp in_ready=0 data=a", a_in_ready, a_out_data);
        end
        step();                                  // stall 3
        a_out_ready = 1'b1;
        step();                                  // A leaves, B to main
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'hB) begin
            failures++; $display("FAIL bp_order_b got valid=%b data=%h exp valid=1 data=b", a_out_valid, a_out_data);
        end
        checks++;
        if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_back got=%b exp=1", a_in_ready); end
        step();                                  // B leaves, C in
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'hC) begin
            failures++; $display("FAIL bp_order_c got valid=%b data=%h exp valid=1 data=c", a_out_valid, a_out_data);
        end
        a_in_valid = 1'b0;
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", a_out_valid); end
        checks++;
        if (a_stall_cnt !== 16'd3) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=3", a_stall_cnt); end
    endtask

    task automatic test_no_skid();
        b_in_valid  = 1'b1;
        b_in_data   = 32'h21;
        b_out_ready = 1'b0;
        step();
        b_in_valid = 1'b0;
        #1;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 32'h21) begin
            failures++; $display("FAIL noskid_load got valid=%b data=%h exp valid=1 data=21", b_out_valid, b_out_data);
        end
        checks++;
        if (b_in_ready !== 1'b0) begin failures++; $display("FAIL noskid_ready_low got=%b exp=0", b_in_ready); end
        b_out_ready = 1'b1;
        #1;
        checks++;
        if (b_in_ready !== 1'b1) begin failures++; $display("FAIL noskid_ready_comb got=%b exp=1", b_in_ready); end
        b_in_valid = 1'b1;
        b_in_data  = 32'h22;
        step();
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 32'h22) begin
            failures++; $display("FAIL noskid_pass got valid=%b data=%h exp valid=1 data=22", b_out_valid, b_out_data);
        end
        b_in_valid = 1'b0;
        step();
        checks++;
        if (b_out_valid !== 1'b0) begin failures++; $display("FAIL noskid_drain got=%b exp=0", b_out_valid); end
    endtask

    task automatic test_flush();
        a_in_valid  = 1'b1;
        a_in_data   = 32'h11;
        a_out_ready = 1'b1;
        step();
        a_in_data   = 32'h12;
        a_out_ready = 1'b0;
        step();                                  // BOTH
        a_flush   = 1'b1;
        a_in_data = 32'hD;
        step();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", a_out_valid); end
        checks++;
        if (a_in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", a_in_ready); end
        step();                                  // nothing resurfaces
        checks++;
        if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_d got=%b exp=0", a_out_valid); end
        a_in_valid  = 1'b1;
        a_in_data   = 32'hE;
        a_out_ready = 1'b1;
        step();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'hE) begin
            failures++; $display("FAIL flush_next_e got valid=%b data=%h exp valid=1 data=e", a_out_valid, a_out_data);
        end
        a_in_valid = 1'b0;
        step();
    endtask

    task automatic test_counter();
        c_in_valid  = 1'b1;
        c_in_data   = 32'h31;
        c_out_ready = 1'b0;
        step();
        c_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (c_stall_cnt !== 4'hF) begin failures++; $display("FAIL cnt_saturate got=%h exp=f", c_stall_cnt); end
        c_stall_clr = 1'b1;
        step();
        c_stall_clr = 1'b0;
        checks++;
        if (c_stall_cnt !== 4'h0) begin failures++; $display("FAIL cnt_clear got=%h exp=0", c_stall_cnt); end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (c_stall_cnt !== 4'h3) begin failures++; $display("FAIL cnt_restart got=%h exp=3", c_stall_cnt); end
        c_flush     = 1'b1;
        c_stall_clr = 1'b1;
        step();
        c_flush     = 1'b0;
        c_stall_clr = 1'b0;
        checks++;
        if (c_stall_cnt !== 4'h0 || c_out_valid !== 1'b0) begin
            failures++; $display("FAIL cnt_flush_clr got cnt=%h valid=%b exp cnt=0 valid=0", c_stall_cnt, c_out_valid);
        end
    endtask

    task automatic test_async_reset();
        a_in_valid  = 1'b1;
        a_in_data   = 32'h55;
        a_out_ready = 1'b0;
        step();
        a_in_valid = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'h55) begin
            failures++; $display("FAIL arst_pre got valid=%b data=%h exp valid=1 data=55", a_out_valid, a_out_data);
        end
        #1;
        rst = 1'b1;                              // mid-cycle, well before next edge
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 32'h0) begin
            failures++; $display("FAIL arst_clear got valid=%b data=%h exp valid=0 data=0", a_out_valid, a_out_data);
        end
        checks++;
        if (a_in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready got=%b exp=1", a_in_ready); end
        #1;
        rst = 1'b0;
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin failures++; $display("FAIL arst_after got=%b exp=0", a_out_valid); end
    endtask

    initial begin
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_stall_clr = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_stall_clr = 1'b0;
        c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0; c_stall_clr = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_no_skid();
        test_flush();
        test_counter();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
